// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// State encoding: RUN = 0, MD_WAIT = 1.
package hazard_pkg;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } state_e;

  localparam logic [4:0] X0 = 5'd0;

  // A load in EX feeding a source the ID instruction actually reads.
  // x0 is never a real dependency.
  function automatic logic load_use_hit(
    input logic       ex_load,
    input logic [4:0] ex_rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       use1,
    input logic       use2
  );
    return ex_load && (ex_rd != X0) &&
           ((use1 && (rs1 == ex_rd)) || (use2 && (rs2 == ex_rd)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr)
      r_cnt <= '0;
    else if (i_inc && !(&r_cnt))
      r_cnt <= r_cnt + W'(1);
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall / bubble / flush sequencer for the 5-stage core, including the MUL/DIV
// launch-and-wait handshake with timeout abort.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rd,
  input  logic             ex_md_valid,
  input  logic             ex_redirect,
  input  logic             dmem_busy,
  input  logic             md_done,
  output logic             md_start,
  output logic             md_abort,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             ex_mem_bubble,
  output logic             mem_wb_write,
  output logic             md_timeout_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int TO_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MD_TIMEOUT - 1);

  state_e          r_state;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_err;

  state_e w_next_state;
  logic   w_to_inc;
  logic   w_to_clr;
  logic   w_load_use;

  assign w_load_use = load_use_hit(id_ex_mem_read, id_ex_rd, id_rs1, id_rs2,
                                   id_use_rs1, id_use_rs2);

  always_comb begin
    md_start      = 1'b0;
    md_abort      = 1'b0;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_write  = 1'b1;
    ex_mem_bubble = 1'b0;
    mem_wb_write  = 1'b1;
    w_next_state  = r_state;
    w_to_inc      = 1'b0;
    w_to_clr      = 1'b0;

    if (dmem_busy) begin
      // Whole pipe holds, including MEM/WB; FSM and timeout are frozen in the ff.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_write = 1'b0;
    end else if (r_state == ST_MD_WAIT) begin
      if (md_done) begin
        w_next_state = ST_RUN;
        w_to_clr     = 1'b1;
      end else if (r_to_cnt == TO_LAST) begin
        // Give up: cancel the unit and let the faulting op retire as a bubble.
        md_abort      = 1'b1;
        ex_mem_bubble = 1'b1;
        w_next_state  = ST_RUN;
        w_to_clr      = 1'b1;
      end else begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        id_ex_write   = 1'b0;
        ex_mem_write  = 1'b0;
        ex_mem_bubble = 1'b1;
        w_to_inc      = 1'b1;
      end
    end else if (ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (w_load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end else if (ex_md_valid) begin
      md_start     = 1'b1;
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      w_next_state = ST_MD_WAIT;
      w_to_clr     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_RUN;
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else if (!dmem_busy) begin
      r_state <= w_next_state;
      if (w_to_clr)
        r_to_cnt <= '0;
      else if (w_to_inc)
        r_to_cnt <= r_to_cnt + TO_W'(1);
      if (md_abort)
        r_err <= 1'b1;
    end
  end

  assign md_timeout_err = r_err;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (~pc_write),
    .i_clr (1'b0),
    .o_cnt (stall_cycles)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_ctrl;

  localparam int TO = 8;

  // {md_start, md_abort, pc_w, if_id_w, if_id_fl, id_ex_w, id_ex_fl, ex_mem_w, ex_mem_bub, mem_wb_w}
  localparam logic [9:0] C_NORM  = 10'b00_1_1_0_1_0_1_0_1;
  localparam logic [9:0] C_LU    = 10'b00_0_0_0_1_1_1_0_1;
  localparam logic [9:0] C_REDIR = 10'b00_1_1_1_1_1_1_0_1;
  localparam logic [9:0] C_START = 10'b10_0_0_0_0_0_0_0_1;
  localparam logic [9:0] C_WAIT  = 10'b00_0_0_0_0_0_0_1_1;
  localparam logic [9:0] C_ABORT = 10'b01_1_1_0_1_0_1_1_1;
  localparam logic [9:0] C_BUSY  = 10'b00_0_0_0_0_0_0_0_0;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_ex_rd = '0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, id_ex_mem_read = 0;
  logic ex_md_valid = 0, ex_redirect = 0, dmem_busy = 0, md_done = 0;
  logic md_start, md_abort, pc_write, if_id_write, if_id_flush, id_ex_write;
  logic id_ex_flush, ex_mem_write, ex_mem_bubble, mem_wb_write, md_timeout_err;
  logic [15:0] stall_cycles;

  typedef struct {
    string       name;
    logic [9:0]  ctl;
    logic [15:0] stall;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  hazard_ctrl #(.MD_TIMEOUT(TO), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
    .ex_md_valid(ex_md_valid), .ex_redirect(ex_redirect),
    .dmem_busy(dmem_busy), .md_done(md_done),
    .md_start(md_start), .md_abort(md_abort), .pc_write(pc_write),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
    .ex_mem_write(ex_mem_write), .ex_mem_bubble(ex_mem_bubble),
    .mem_wb_write(mem_wb_write), .md_timeout_err(md_timeout_err),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      logic [9:0] act;
      e   = q.pop_front();
      act = {md_start, md_abort, pc_write, if_id_write, if_id_flush, id_ex_write,
             id_ex_flush, ex_mem_write, ex_mem_bubble, mem_wb_write};
      n_vec++;
      if (act !== e.ctl || stall_cycles !== e.stall || md_timeout_err !== e.err) begin
        n_bad++;
        $display("FAIL %s: ctl=%b stall=%0d err=%b, expected ctl=%b stall=%0d err=%b",
                 e.name, act, stall_cycles, md_timeout_err, e.ctl, e.stall, e.err);
      end
    end
  end

  // Apply one cycle of inputs just after the edge; chk=0 drives without an expectation.
  task automatic vec(input string nm, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic mr, input logic [4:0] rd,
                     input logic mdv, input logic rdr, input logic busy, input logic done,
                     input logic rst, input logic chk,
                     input logic [9:0] ctl, input int st, input logic err);
    exp_t e;
    @(posedge clk);
    #1;
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_ex_mem_read = mr; id_ex_rd = rd; ex_md_valid = mdv; ex_redirect = rdr;
    dmem_busy = busy; md_done = done; rst_n = rst;
    if (chk) begin
      e.name = nm; e.ctl = ctl; e.stall = 16'(st); e.err = err;
      q.push_back(e);
    end
  endtask

  task automatic idle(input string nm, input int st, input logic err);
    vec(nm, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 1, 1, C_NORM, st, err);
  endtask

  initial begin
    vec("rst0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0, 0);
    vec("rst1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0, 0);
    idle("reset_state", 0, 0);
    // load-use on rs1 (lw x5 ; add x6,x5,x1), then released
    vec("lu_rs1",      5, 1, 1, 1, 1, 5, 0, 0, 0, 0, 1, 1, C_LU,   0, 0);
    vec("lu_resolved", 5, 1, 1, 1, 0, 5, 0, 0, 0, 0, 1, 1, C_NORM, 1, 0);
    vec("lu_rs2",      3, 7, 1, 1, 1, 7, 0, 0, 0, 0, 1, 1, C_LU,   1, 0);
    idle("after_lu_rs2", 2, 0);
    vec("rs2_unused",  3, 7, 1, 0, 1, 7, 0, 0, 0, 0, 1, 1, C_NORM, 2, 0);
    // redirect beats load-use
    vec("redir_lu",    5, 1, 1, 1, 1, 5, 0, 1, 0, 0, 1, 1, C_REDIR, 2, 0);
    idle("after_redir", 2, 0);
    // MUL: start, 5 wait cycles, md_done on the 6th wait cycle
    vec("md_start", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, C_START, 2, 0);
    for (int i = 0; i < 5; i++)
      vec("md_wait", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, C_WAIT, 3 + i, 0);
    vec("md_release", 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, C_NORM, 8, 0);
    idle("after_md", 8, 0);
    vec("done_in_run", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, C_NORM, 8, 0);
    // dmem_busy inside MD_WAIT freezes the timeout: 1+6 non-busy waits stay below TO-1
    vec("md2_start", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, C_START, 8, 0);
    vec("md2_wait0", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, C_WAIT, 9, 0);
    for (int i = 0; i < 3; i++)
      vec("md2_busy", 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 1, C_BUSY, 10 + i, 0);
    for (int i = 0; i < 6; i++)
      vec("md2_wait", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, C_WAIT, 13 + i, 0);
    vec("md2_release", 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, C_NORM, 19, 0);
    idle("after_md2", 19, 0);
    // dmem_busy in RUN outranks a load-use hazard
    vec("busy_run_lu", 5, 1, 1, 1, 1, 5, 0, 0, 1, 0, 1, 1, C_BUSY, 19, 0);
    idle("after_busy", 20, 0);
    // timeout: abort on the TO-th wait cycle, error becomes sticky
    vec("to_start", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, C_START, 20, 0);
    for (int i = 0; i < TO - 1; i++)
      vec("to_wait", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, C_WAIT, 21 + i, 0);
    vec("to_abort", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, C_ABORT, 28, 0);
    idle("after_abort", 28, 1);
    vec("to_back_in_run", 5, 1, 1, 1, 1, 5, 0, 0, 0, 0, 1, 1, C_LU, 28, 1);
    idle("err_sticky", 29, 1);
    // reset while waiting on MUL/DIV
    vec("md3_start", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, C_START, 29, 1);
    vec("md3_wait",  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, C_WAIT, 30, 1);
    vec("md3_rst",   0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, C_NORM, 0, 0);
    idle("post_reset", 0, 0);
    vec("load_x0", 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, C_NORM, 0, 0);
    idle("final", 0, 0);
    @(posedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
